// File: rtl/h264_pkg.sv
// Shared types and helpers for the intra 4x4 predicted-mode block.
// Contents: mode enum, controller state enum, FIFO payload struct,
// sub-block coordinate helpers for the standard 4x4 scan order.
package h264_pkg;

    localparam int unsigned MODE_W = 4;
    localparam int unsigned REM_W  = 3;

    typedef enum logic [MODE_W-1:0] {
        VERT    = 4'd0,
        HOR     = 4'd1,
        DC      = 4'd2,
        DIAG_DL = 4'd3,
        DIAG_DR = 4'd4,
        VERT_R  = 4'd5,
        HOR_D   = 4'd6,
        VERT_L  = 4'd7,
        HOR_U   = 4'd8
    } intra4x4_mode_t;

    localparam logic [MODE_W-1:0] PRED_DC = DC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2
    } mp_state_t;

    typedef struct packed {
        logic             flag;
        logic [REM_W-1:0] rem;
    } mp_out_t;

    // Column of a sub-block within the macroblock.
    function automatic logic [1:0] sub_xx(input logic [3:0] s);
        return {s[2], s[0]};
    endfunction

    // Row of a sub-block within the macroblock.
    function automatic logic [1:0] sub_yy(input logic [3:0] s);
        return {s[3], s[1]};
    endfunction

    // Scan index of the sub-block at column x, row y.
    function automatic logic [3:0] blk_idx(input logic [1:0] x, input logic [1:0] y);
        return {y[1], x[1], y[0], x[0]};
    endfunction

endpackage

// File: rtl/h264_intra4x4_modepred_if.sv
// Mode handshake bundle.
// Upstream: MSTROBEI/MODEI in, MREADYO back.
// Downstream: MVALIDO/PREVFLAGO/REMMODEO out, MREADYI back.
interface h264_intra4x4_modepred_if;
    import h264_pkg::*;

    logic              MSTROBEI;
    logic [MODE_W-1:0] MODEI;
    logic              MREADYO;
    logic              MVALIDO;
    logic              PREVFLAGO;
    logic [REM_W-1:0]  REMMODEO;
    logic              MREADYI;

    modport master (
        output MSTROBEI, MODEI, MREADYI,
        input  MREADYO, MVALIDO, PREVFLAGO, REMMODEO
    );

    modport slave (
        input  MSTROBEI, MODEI, MREADYI,
        output MREADYO, MVALIDO, PREVFLAGO, REMMODEO
    );

endinterface

// File: rtl/h264_intra4x4_modepred_fifo.sv
// Two-entry valid/ready FIFO carrying {flag, rem}; head is registered.
// Ports: clk/rst, push/din (write side), valid_o/dout_o/ready_i (read
// side), level_nxt_c = occupancy after this cycle (combinational).
module h264_modepred_fifo
    import h264_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  mp_out_t    din,
    output logic       valid_o,
    output mp_out_t    dout_o,
    input  logic       ready_i,
    output logic [1:0] level_nxt_c
);

    mp_out_t    head_q, head_d;
    mp_out_t    tail_q, tail_d;
    logic [1:0] level_q, level_d;
    logic       valid_q, valid_d;
    logic       pop;

    // Pop first so a simultaneous push lands behind the remaining entry.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        pop     = valid_q && ready_i;
        if (pop) begin
            head_d  = tail_q;
            level_d = level_q - 2'd1;
        end
        if (push && (level_d != 2'd2)) begin
            if (level_d == 2'd0) begin
                head_d = din;
            end else begin
                tail_d = din;
            end
            level_d = level_d + 2'd1;
        end
        valid_d     = (level_d != 2'd0);
        level_nxt_c = level_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign dout_o  = head_q;

endmodule

// File: rtl/h264_intra4x4_modepred.sv
// Derives H.264 predicted intra 4x4 mode from left/top neighbours and
// emits {prev_intra4x4_pred_mode_flag, rem_intra4x4_pred_mode} per sub-block.
// Ports: CLK, RESET (sync, active high), NEWSLICE/NEWLINE pulses,
// mp (mode handshake bundle, slave side), MBDONEO (macroblock done pulse).
module h264_intra4x4_modepred
    import h264_pkg::*;
#(
    parameter int unsigned MBWIDTH_MAX = 120
)(
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      NEWSLICE,
    input  logic                      NEWLINE,
    h264_intra4x4_modepred_if.slave   mp,
    output logic                      MBDONEO
);

    localparam int unsigned MBX_W     = (MBWIDTH_MAX > 1) ? $clog2(MBWIDTH_MAX) : 1;
    localparam int unsigned ADDR_W    = MBX_W + 2;
    localparam int unsigned RAM_DEPTH = MBWIDTH_MAX * 4;
    localparam logic [MBX_W-1:0] MBX_LAST = MBX_W'(MBWIDTH_MAX - 1);

    mp_state_t         state_q, state_d;
    logic [3:0]        subcnt_q, subcnt_d;
    logic [MBX_W-1:0]  mbx_q, mbx_d;
    logic              topvalid_q, topvalid_d;
    logic              mready_q, mready_d;
    logic              mbdone_q, mbdone_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [MODE_W-1:0] pred_q, pred_d;
    logic [MODE_W-1:0] cur_q [16];
    logic [MODE_W-1:0] cur_d [16];
    logic [MODE_W-1:0] left_q [4];
    logic [MODE_W-1:0] left_d [4];
    logic [MODE_W-1:0] ram_q [RAM_DEPTH];
    logic [MODE_W-1:0] rdata_q;

    logic [1:0]        xx, yy;
    logic [ADDR_W-1:0] ram_addr;
    logic [MODE_W-1:0] a_mode, b_mode;
    logic              a_ok, b_ok;
    logic              accept, abort, push, ram_we;
    mp_out_t           out_c;
    mp_out_t           head;
    logic [1:0]        level_nxt;

    // Neighbour selection for the sub-block currently addressed by subcnt.
    always_comb begin
        xx       = sub_xx(subcnt_q);
        yy       = sub_yy(subcnt_q);
        ram_addr = {mbx_q, xx};
        if (xx != 2'd0) begin
            a_mode = cur_q[blk_idx(xx - 2'd1, yy)];
            a_ok   = 1'b1;
        end else begin
            a_mode = left_q[yy];
            a_ok   = (mbx_q != '0);
        end
        if (yy != 2'd0) begin
            b_mode = cur_q[blk_idx(xx, yy - 2'd1)];
            b_ok   = 1'b1;
        end else begin
            b_mode = rdata_q;
            b_ok   = topvalid_q;
        end
    end

    // Controller next state; a slice/line pulse overrides any in-flight work.
    always_comb begin
        state_d    = state_q;
        subcnt_d   = subcnt_q;
        mbx_d      = mbx_q;
        topvalid_d = topvalid_q;
        mode_d     = mode_q;
        pred_d     = pred_q;
        cur_d      = cur_q;
        left_d     = left_q;
        mbdone_d   = 1'b0;
        push       = 1'b0;
        ram_we     = 1'b0;
        abort      = NEWSLICE || NEWLINE;
        accept     = mp.MSTROBEI && mready_q;

        out_c.flag = (mode_q == pred_q);
        if (out_c.flag) begin
            out_c.rem = '0;
        end else if (mode_q < pred_q) begin
            out_c.rem = mode_q[REM_W-1:0];
        end else begin
            out_c.rem = REM_W'(mode_q - 4'd1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mode_d  = mp.MODEI;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                pred_d  = (a_ok && b_ok) ? ((a_mode < b_mode) ? a_mode : b_mode) : PRED_DC;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                push             = 1'b1;
                cur_d[subcnt_q]  = mode_q;
                ram_we           = (yy == 2'd3);
                subcnt_d         = subcnt_q + 4'd1;
                if (subcnt_q == 4'd15) begin
                    // Column 3 becomes the next MB's left edge; block 15 is mode_q itself.
                    for (int y = 0; y < 3; y++) begin
                        left_d[y] = cur_q[blk_idx(2'd3, 2'(y))];
                    end
                    left_d[3] = mode_q;
                    mbx_d     = (mbx_q == MBX_LAST) ? mbx_q : mbx_q + MBX_W'(1);
                    mbdone_d  = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            subcnt_d   = 4'd0;
            mbx_d      = '0;
            topvalid_d = !NEWSLICE;
            cur_d      = cur_q;
            left_d     = left_q;
            mbdone_d   = 1'b0;
            push       = 1'b0;
            ram_we     = 1'b0;
        end
    end

    // Ready is registered from the post-cycle state and FIFO occupancy.
    always_comb begin
        mready_d = (state_d == ST_IDLE) && (level_nxt < 2'd2);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            subcnt_q   <= 4'd0;
            mbx_q      <= '0;
            topvalid_q <= 1'b0;
            mready_q   <= 1'b1;
            mbdone_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            subcnt_q   <= subcnt_d;
            mbx_q      <= mbx_d;
            topvalid_q <= topvalid_d;
            mready_q   <= mready_d;
            mbdone_q   <= mbdone_d;
        end
    end

    // Datapath registers; contents are always written before being used.
    always_ff @(posedge CLK) begin
        mode_q <= mode_d;
        pred_q <= pred_d;
        cur_q  <= cur_d;
        left_q <= left_d;
    end

    // Top-mode line store: one write port, registered read issued on accept.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram_q[ram_addr] <= mode_q;
        end
        if (accept) begin
            rdata_q <= ram_q[ram_addr];
        end
    end

    h264_modepred_fifo u_fifo (
        .clk         (CLK),
        .rst         (RESET),
        .push        (push),
        .din         (out_c),
        .valid_o     (mp.MVALIDO),
        .dout_o      (head),
        .ready_i     (mp.MREADYI),
        .level_nxt_c (level_nxt)
    );

    assign mp.PREVFLAGO = head.flag;
    assign mp.REMMODEO  = head.rem;
    assign mp.MREADYO   = mready_q;
    assign MBDONEO      = mbdone_q;

endmodule

// File: tb/tb_h264_intra4x4_modepred.sv
// Scoreboard bench: picture-level reference model predicts {flag, rem},
// a monitor process compares against the DUT output stream.
module tb_h264_intra4x4_modepred;
    import h264_pkg::*;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic newslice = 1'b0;
    logic newline  = 1'b0;
    logic mbdone;

    h264_intra4x4_modepred_if mp_if();

    h264_intra4x4_modepred dut (
        .CLK      (clk),
        .RESET    (rst),
        .NEWSLICE (newslice),
        .NEWLINE  (newline),
        .mp       (mp_if),
        .MBDONEO  (mbdone)
    );

    always #5 clk = ~clk;

    int         chk_cnt     = 0;
    int         pass_cnt    = 0;
    int         mbdone_seen = 0;
    int         mbdone_exp  = 0;
    bit         hold        = 1'b1;
    logic [3:0] exp_q[$];

    // Reference model: the slice as a 2-D picture of 4x4 block modes.
    int pic[int];
    int row   = 0;
    int mbx_m = 0;
    int sub_m = 0;

    task automatic check(input string name, input int act, input int req);
        chk_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    function automatic int pic_at(input int gy, input int gx);
        int k;
        k = gy * 4096 + gx;
        return pic.exists(k) ? pic[k] : 15;
    endfunction

    task automatic model_step(input int m, output logic [3:0] e);
        int xx, yy, gx, gy, a, b, pred, rem;
        bit flag;
        xx = (sub_m % 2) + 2 * ((sub_m / 4) % 2);
        yy = ((sub_m / 2) % 2) + 2 * (sub_m / 8);
        gx = mbx_m * 4 + xx;
        gy = row * 4 + yy;
        if (gx > 0 && gy > 0) begin
            a    = pic_at(gy, gx - 1);
            b    = pic_at(gy - 1, gx);
            pred = (a < b) ? a : b;
        end else begin
            pred = 2;
        end
        flag = (m == pred);
        rem  = flag ? 0 : ((m < pred) ? m : m - 1);
        pic[gy * 4096 + gx] = m;
        sub_m++;
        if (sub_m == 16) begin
            sub_m = 0;
            mbx_m++;
            mbdone_exp++;
        end
        e = {flag, 3'(rem)};
    endtask

    task automatic pulse(input bit slice, input bit line);
        @(negedge clk);
        newslice = slice;
        newline  = line;
        @(negedge clk);
        newslice = 1'b0;
        newline  = 1'b0;
        if (slice) begin
            pic.delete();
            row = 0;
        end else begin
            row++;
        end
        mbx_m = 0;
        sub_m = 0;
    endtask

    // Strobe until accepted; return once the DUT is back in IDLE.
    task automatic send(input int m);
        int         waitc;
        logic [3:0] e;
        waitc = 0;
        @(negedge clk);
        mp_if.MSTROBEI = 1'b1;
        mp_if.MODEI    = 4'(m);
        while (!mp_if.MREADYO) begin
            waitc++;
            if (waitc > 300) begin
                check("accept_timeout", 0, 1);
                mp_if.MSTROBEI = 1'b0;
                return;
            end
            @(negedge clk);
        end
        model_step(m, e);
        exp_q.push_back(e);
        @(negedge clk);
        mp_if.MSTROBEI = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Accepted mode killed by NEWLINE during FETCH: no output expected.
    task automatic send_abort(input int m);
        int waitc;
        waitc = 0;
        @(negedge clk);
        mp_if.MSTROBEI = 1'b1;
        mp_if.MODEI    = 4'(m);
        while (!mp_if.MREADYO && waitc < 300) begin
            waitc++;
            @(negedge clk);
        end
        check("abort_accept", int'(mp_if.MREADYO), 1);
        @(negedge clk);
        mp_if.MSTROBEI = 1'b0;
        newline        = 1'b1;
        @(negedge clk);
        newline = 1'b0;
        row++;
        mbx_m = 0;
        sub_m = 0;
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send($urandom_range(8));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mp_if.MVALIDO) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
    endtask

    // Monitor: randomised downstream ready, pops and compares on each transfer.
    initial begin
        logic [3:0] got, e;
        mp_if.MREADYI = 1'b0;
        forever begin
            @(negedge clk);
            mp_if.MREADYI = hold ? 1'b0 : ($urandom_range(3) != 0);
            if (mp_if.MVALIDO && mp_if.MREADYI) begin
                got = {mp_if.PREVFLAGO, mp_if.REMMODEO};
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'(got), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("flag_rem", int'(got), int'(e));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mbdone) mbdone_seen++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        mp_if.MSTROBEI = 1'b0;
        mp_if.MODEI    = 4'd0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_mreadyo", int'(mp_if.MREADYO), 1);
        check("rst_mvalido", int'(mp_if.MVALIDO), 0);
        check("rst_prevflag", int'(mp_if.PREVFLAGO), 0);
        check("rst_remmode", int'(mp_if.REMMODEO), 0);
        check("rst_mbdone", int'(mbdone), 0);

        // MB 0 all DC, first one timed against the 3-cycle latency.
        pulse(1'b1, 1'b0);
        @(negedge clk);
        mp_if.MSTROBEI = 1'b1;
        mp_if.MODEI    = 4'd2;
        check("ready_idle", int'(mp_if.MREADYO), 1);
        model_step(2, e);
        exp_q.push_back(e);
        @(negedge clk);
        mp_if.MSTROBEI = 1'b0;
        check("ready_fetch", int'(mp_if.MREADYO), 0);
        check("valid_t1", int'(mp_if.MVALIDO), 0);
        @(negedge clk);
        check("valid_t2", int'(mp_if.MVALIDO), 0);
        @(negedge clk);
        check("valid_t3", int'(mp_if.MVALIDO), 1);
        hold = 1'b0;
        for (int i = 1; i < 16; i++) send(2);
        wait_drain();
        repeat (2) @(negedge clk);
        check("mbdone_mb0", mbdone_seen, 1);

        // Unavailable neighbours, then left-only neighbour.
        pulse(1'b1, 1'b0);
        send(0);
        send(1);
        send_rand(14);

        // Line 1 all HOR, line 2 MB0 all VERT, then MB1 block 0 = HOR.
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 32; i++) send(1);
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) send(0);
        send(1);
        send_rand(15);
        wait_drain();

        // Backpressure: two entries fill the FIFO, third strobe ignored.
        pulse(1'b1, 1'b0);
        hold = 1'b1;
        send($urandom_range(8));
        send($urandom_range(8));
        check("ready_full", int'(mp_if.MREADYO), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mp_if.MSTROBEI = 1'b1;
            mp_if.MODEI    = 4'd5;
            check("ready_full_hold", int'(mp_if.MREADYO), 0);
        end
        @(negedge clk);
        mp_if.MSTROBEI = 1'b0;
        hold = 1'b0;
        wait_drain();
        check("valid_after_drain", int'(mp_if.MVALIDO), 0);

        // NEWLINE during FETCH of sub-block 5 of MB1.
        pulse(1'b1, 1'b0);
        send_rand(16);
        send_rand(5);
        send_abort($urandom_range(8));
        send_rand(16);

        // Random slice of 3 lines x 3 MBs, then combined slice+line pulse.
        pulse(1'b1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            if (r > 0) pulse(1'b0, 1'b1);
            send_rand(48);
        end
        pulse(1'b1, 1'b1);
        send_rand(32);

        wait_drain();
        repeat (3) @(negedge clk);
        check("mbdone_total", mbdone_seen, mbdone_exp);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
